// File: rtl/cp0_interrupt_ctrl_if.sv
// cp0_interrupt_ctrl_if: pipeline <-> CP0 interrupt controller bundle
// master: pipeline side (drives irq/CP0 access/eret/resume/int_safe)
// slave:  controller side (drives cp0_rdata, int_req/take/vector, epc, int_busy)
interface cp0_interrupt_ctrl_if;
    logic [2:0]  irq_in;
    logic [4:0]  cp0_rd;
    logic        mtc0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        eret_i;
    logic [31:0] resume_pc;
    logic        int_safe;
    logic        int_req;
    logic        int_take;
    logic [31:0] int_vector;
    logic [31:0] epc;
    logic        int_busy;
    modport master (
        output irq_in, cp0_rd, mtc0_we, cp0_wdata, eret_i, resume_pc, int_safe,
        input  cp0_rdata, int_req, int_take, int_vector, epc, int_busy
    );
    modport slave (
        input  irq_in, cp0_rd, mtc0_we, cp0_wdata, eret_i, resume_pc, int_safe,
        output cp0_rdata, int_req, int_take, int_vector, epc, int_busy
    );
endinterface

// File: rtl/cp0_interrupt_ctrl.sv
// cp0_interrupt_ctrl: CP0 interrupt latch, fixed-priority arbiter and entry sequencer
// clk, rst_n: pipeline clock, asynchronous active-low reset
// bus (slave): irq levels, mtc0/mfc0 access, eret, resume pc, int_safe in;
//              cp0_rdata, int_req, int_take, int_vector, epc, int_busy out
module cp0_interrupt_ctrl #(
    parameter logic [31:0] VEC2 = 32'h0000_0400,
    parameter logic [31:0] VEC1 = 32'h0000_0600,
    parameter logic [31:0] VEC0 = 32'h0000_0800
) (
    input logic clk,
    input logic rst_n,
    cp0_interrupt_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ISR} state_t;
    state_t state_q, state_d;
    logic [2:0]  irq_prev_q, pending_q, pending_d, mask_q, mask_d, rise, eligible;
    logic [1:0]  winner_q, winner_d;
    logic        dis_q, dis_d, take;
    logic [31:0] epc_q, epc_d;
    assign rise     = bus.irq_in & ~irq_prev_q;
    assign eligible = pending_q & mask_q;
    assign take     = (state_q == WAIT) & bus.int_safe;
    assign bus.int_req    = state_q == WAIT;
    assign bus.int_take   = take;
    assign bus.int_busy   = state_q == ISR;
    assign bus.epc        = epc_q;
    assign bus.int_vector = winner_q == 2'd2 ? VEC2 : winner_q == 2'd1 ? VEC1 : VEC0;
    always_comb begin
        cp0_rdata_mux: begin
            bus.cp0_rdata = bus.cp0_rd == 5'h16 ? {31'b0, dis_q} :
                            bus.cp0_rd == 5'h17 ? {29'b0, mask_q} :
                            bus.cp0_rd == 5'h0e ? epc_q :
                            bus.cp0_rd == 5'h0d ? {29'b0, pending_q} : 32'b0;
        end
    end
    always_comb begin
        // a fresh rise on the winner in the entry cycle survives the clear
        pending_d = (pending_q & ~(take ? 3'b001 << winner_q : 3'b000)) | rise;
        mask_d    = bus.mtc0_we && bus.cp0_rd == 5'h17 ? bus.cp0_wdata[2:0] : mask_q;
        epc_d     = take ? bus.resume_pc :
                    bus.mtc0_we && bus.cp0_rd == 5'h0e ? bus.cp0_wdata : epc_q;
        dis_d     = take ? 1'b1 : bus.eret_i ? 1'b0 :
                    bus.mtc0_we && bus.cp0_rd == 5'h16 ? bus.cp0_wdata[0] : dis_q;
        winner_d  = winner_q;
        state_d   = state_q;
        case (state_q)
            IDLE: if (|eligible && !dis_q) begin
                state_d  = WAIT;
                winner_d = eligible[2] ? 2'd2 : eligible[1] ? 2'd1 : 2'd0;
            end
            WAIT: state_d = bus.int_safe ? ISR : WAIT;
            ISR:  state_d = bus.eret_i ? IDLE : ISR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            irq_prev_q <= 3'b000;
            pending_q  <= 3'b000;
            mask_q     <= 3'b000;
            winner_q   <= 2'd0;
            dis_q      <= 1'b0;
            epc_q      <= 32'b0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= bus.irq_in;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            winner_q   <= winner_d;
            dis_q      <= dis_d;
            epc_q      <= epc_d;
        end
    end
endmodule

// File: tb/tb_cp0_interrupt_ctrl.sv
// tb_cp0_interrupt_ctrl: directed self-checking bench for cp0_interrupt_ctrl
module tb_cp0_interrupt_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    cp0_interrupt_ctrl_if bus ();
    cp0_interrupt_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.cp0_rd = a;
        bus.mtc0_we = 1'b1;
        bus.cp0_wdata = d;
        step();
        bus.mtc0_we = 1'b0;
    endtask
    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_rd = a;
        #1;
        check(tag, bus.cp0_rdata, exp);
    endtask
    initial begin
        rst_n = 1'b0;
        bus.irq_in = 3'b000;
        bus.cp0_rd = 5'h00;
        bus.mtc0_we = 1'b0;
        bus.cp0_wdata = 32'b0;
        bus.eret_i = 1'b0;
        bus.resume_pc = 32'b0;
        bus.int_safe = 1'b0;
        #1;
        check("rst_req", {31'b0, bus.int_req}, 32'd0);
        check("rst_take", {31'b0, bus.int_take}, 32'd0);
        check("rst_busy", {31'b0, bus.int_busy}, 32'd0);
        check("rst_vec", bus.int_vector, 32'h800);
        rd("rst_mask", 5'h17, 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        // single source 0 entry
        bus.int_safe = 1'b1;
        bus.resume_pc = 32'h40;
        wr(5'h17, 32'h7);
        bus.irq_in = 3'b001;
        step();
        bus.irq_in = 3'b000;
        check("t1_noreq", {31'b0, bus.int_req}, 32'd0);
        step();
        check("t1_take", {31'b0, bus.int_take}, 32'd1);
        check("t1_vec", bus.int_vector, 32'h800);
        step();
        check("t1_take_off", {31'b0, bus.int_take}, 32'd0);
        check("t1_busy", {31'b0, bus.int_busy}, 32'd1);
        check("t1_epc", bus.epc, 32'h40);
        rd("t1_dis", 5'h16, 32'd1);
        rd("t1_pend", 5'h0d, 32'd0);
        // two sources together, source 1 wins
        bus.resume_pc = 32'h44;
        bus.eret_i = 1'b1;
        step();
        bus.eret_i = 1'b0;
        check("t2_busy_off", {31'b0, bus.int_busy}, 32'd0);
        rd("t2_dis", 5'h16, 32'd0);
        bus.irq_in = 3'b011;
        step();
        bus.irq_in = 3'b000;
        step();
        check("t2_take", {31'b0, bus.int_take}, 32'd1);
        check("t2_vec", bus.int_vector, 32'h600);
        step();
        rd("t2_pend", 5'h0d, 32'd1);
        check("t2_epc", bus.epc, 32'h44);
        // stall in WAIT for 4 cycles
        bus.int_safe = 1'b0;
        bus.resume_pc = 32'h80;
        bus.eret_i = 1'b1;
        step();
        bus.eret_i = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("t3_req", {31'b0, bus.int_req}, 32'd1);
            check("t3_notake", {31'b0, bus.int_take}, 32'd0);
            check("t3_epc_hold", bus.epc, 32'h44);
            step();
        end
        bus.int_safe = 1'b1;
        #1;
        check("t3_take", {31'b0, bus.int_take}, 32'd1);
        check("t3_vec", bus.int_vector, 32'h800);
        step();
        check("t3_take_once", {31'b0, bus.int_take}, 32'd0);
        check("t3_epc", bus.epc, 32'h80);
        rd("t3_pend", 5'h0d, 32'd0);
        // masked source, then unmask
        bus.int_safe = 1'b0;
        bus.eret_i = 1'b1;
        step();
        bus.eret_i = 1'b0;
        wr(5'h0d, 32'h7);
        rd("t4_pend_ro", 5'h0d, 32'd0);
        rd("t4_other", 5'h01, 32'd0);
        wr(5'h17, 32'h6);
        bus.irq_in = 3'b001;
        step();
        bus.irq_in = 3'b000;
        step();
        check("t4_masked", {31'b0, bus.int_req}, 32'd0);
        rd("t4_pend", 5'h0d, 32'd1);
        bus.cp0_rd = 5'h17;
        bus.mtc0_we = 1'b1;
        bus.cp0_wdata = 32'h7;
        #1;
        check("t4_rd_old", bus.cp0_rdata, 32'h6);
        step();
        bus.mtc0_we = 1'b0;
        check("t4_req_late", {31'b0, bus.int_req}, 32'd0);
        step();
        check("t4_req", {31'b0, bus.int_req}, 32'd1);
        bus.int_safe = 1'b1;
        step();
        check("t4_busy", {31'b0, bus.int_busy}, 32'd1);
        // source 2 during ISR waits for eret; entry/eret priorities
        bus.irq_in = 3'b100;
        step();
        bus.irq_in = 3'b000;
        step();
        check("t5_isr_noreq", {31'b0, bus.int_req}, 32'd0);
        rd("t5_pend", 5'h0d, 32'h4);
        bus.eret_i = 1'b1;
        bus.mtc0_we = 1'b1;
        bus.cp0_rd = 5'h16;
        bus.cp0_wdata = 32'h1;
        step();
        bus.eret_i = 1'b0;
        bus.mtc0_we = 1'b0;
        check("t5_busy_off", {31'b0, bus.int_busy}, 32'd0);
        rd("t5_eret_wins", 5'h16, 32'd0);
        step();
        check("t5_take", {31'b0, bus.int_take}, 32'd1);
        check("t5_vec", bus.int_vector, 32'h400);
        bus.mtc0_we = 1'b1;
        bus.cp0_rd = 5'h0e;
        bus.cp0_wdata = 32'hdead;
        bus.resume_pc = 32'h100;
        bus.irq_in = 3'b100;
        step();
        bus.mtc0_we = 1'b0;
        bus.irq_in = 3'b000;
        check("t5_epc_entry_wins", bus.epc, 32'h100);
        rd("t5_dis", 5'h16, 32'd1);
        rd("t5_pend_kept", 5'h0d, 32'h4);
        // reset during WAIT
        bus.int_safe = 1'b0;
        bus.eret_i = 1'b1;
        step();
        bus.eret_i = 1'b0;
        step();
        check("t6_req", {31'b0, bus.int_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_req_drop", {31'b0, bus.int_req}, 32'd0);
        check("t6_vec", bus.int_vector, 32'h800);
        check("t6_epc", bus.epc, 32'd0);
        rd("t6_mask", 5'h17, 32'd0);
        rd("t6_pend", 5'h0d, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("t6_idle", {31'b0, bus.int_req}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
